// File: rtl/uart_comm_pkg.sv
// Shared types and sizes for the UART command slave: receive/transmit state
// encodings and the command length in bytes.
package uart_comm_pkg;

    localparam int CMD_BYTES = 3;
    localparam int CMD_W     = 8 * CMD_BYTES;

    typedef enum logic [1:0] {
        RX_B0 = 2'd0,
        RX_B1 = 2'd1,
        RX_B2 = 2'd2
    } rx_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_BUSY = 1'b1
    } tx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, and a rdy flag
// that holds the byte until the consumer pulses clr_rdy.
module uart_rx #(
    parameter logic [15:0] BAUD_DIV = 16'd2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rdy
);

    logic        rx_meta_q;
    logic        rx_sync_q;
    logic        busy_q;
    logic        rdy_q;
    logic [15:0] baud_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            if (clr_rdy) begin
                rdy_q <= 1'b0;
            end
            if (!busy_q) begin
                // Half a bit period lands the first sample in the middle of the start bit.
                if (!rx_sync_q) begin
                    busy_q     <= 1'b1;
                    bit_cnt_q  <= '0;
                    baud_cnt_q <= BAUD_DIV >> 1;
                end
            end else if (baud_cnt_q != 16'd0) begin
                baud_cnt_q <= baud_cnt_q - 16'd1;
            end else begin
                baud_cnt_q <= BAUD_DIV - 16'd1;
                bit_cnt_q  <= bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd0) begin
                    if (rx_sync_q) begin
                        busy_q <= 1'b0;
                    end
                end else if (bit_cnt_q < 4'd9) begin
                    shift_q <= {rx_sync_q, shift_q[7:1]};
                end else begin
                    busy_q <= 1'b0;
                    rdy_q  <= 1'b1;
                end
            end
        end
    end

    assign rx_data = shift_q;
    assign rdy     = rdy_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: loads a 10-bit frame on trmt and pulses tx_done for
// one cycle at the end of the stop bit. The line idles high, including in reset.
module uart_tx #(
    parameter logic [15:0] BAUD_DIV = 16'd2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    logic        busy_q;
    logic        done_q;
    logic [9:0]  shift_q;
    logic [15:0] baud_cnt_q;
    logic [3:0]  bit_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_q    <= '1;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (trmt && !busy_q) begin
                shift_q    <= {1'b1, tx_data, 1'b0};
                busy_q     <= 1'b1;
                bit_cnt_q  <= '0;
                baud_cnt_q <= BAUD_DIV - 16'd1;
            end else if (busy_q) begin
                if (baud_cnt_q != 16'd0) begin
                    baud_cnt_q <= baud_cnt_q - 16'd1;
                end else if (bit_cnt_q == 4'd9) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    shift_q    <= {1'b1, shift_q[9:1]};
                    bit_cnt_q  <= bit_cnt_q + 4'd1;
                    baud_cnt_q <= BAUD_DIV - 16'd1;
                end
            end
        end
    end

    assign TX      = shift_q[0];
    assign tx_done = done_q;

endmodule

// File: rtl/uart_comm_slv.sv
// UART command slave: assembles three received bytes into a 24-bit command
// (with an inter-byte timeout) and transmits single response bytes on request.
module uart_comm_slv
    import uart_comm_pkg::*;
#(
    parameter logic [21:0] TIMEOUT_CYC = 22'd2_500_000,
    parameter logic [15:0] BAUD_DIV    = 16'd2604
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RX,
    output logic             TX,
    output logic [CMD_W-1:0] cmd,
    output logic             cmd_rdy,
    input  logic             clr_cmd_rdy,
    input  logic [7:0]       resp,
    input  logic             send_resp,
    output logic             resp_sent
);

    logic [7:0]       rx_data;
    logic             rx_rdy;
    logic             clr_rdy;
    logic             tx_done;

    rx_state_t        rx_state_q;
    logic [15:0]      shadow_q;
    logic [CMD_W-1:0] cmd_q;
    logic             cmd_rdy_q;
    logic [21:0]      tmo_cnt_q;

    tx_state_t        tx_state_q;
    logic [7:0]       hold_q;
    logic             trmt_q;
    logic             resp_sent_q;

    // Every byte is taken the cycle it appears, so rdy is acknowledged at once.
    assign clr_rdy = rx_rdy;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rx_rdy)
    );

    uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt_q),
        .tx_data (hold_q),
        .TX      (TX),
        .tx_done (tx_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q <= RX_B0;
            shadow_q   <= '0;
            cmd_q      <= '0;
            cmd_rdy_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            // Listed first so a completion in the same cycle overrides the clear.
            if (clr_cmd_rdy) begin
                cmd_rdy_q <= 1'b0;
            end
            if (rx_rdy) begin
                tmo_cnt_q <= '0;
                case (rx_state_q)
                    RX_B0: begin
                        shadow_q[15:8] <= rx_data;
                        rx_state_q     <= RX_B1;
                    end
                    RX_B1: begin
                        shadow_q[7:0] <= rx_data;
                        rx_state_q    <= RX_B2;
                    end
                    default: begin
                        cmd_q      <= {shadow_q, rx_data};
                        cmd_rdy_q  <= 1'b1;
                        rx_state_q <= RX_B0;
                    end
                endcase
            end else if (rx_state_q == RX_B0) begin
                tmo_cnt_q <= '0;
            end else if (tmo_cnt_q == TIMEOUT_CYC - 22'd1) begin
                tmo_cnt_q  <= '0;
                shadow_q   <= '0;
                rx_state_q <= RX_B0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 22'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q  <= TX_IDLE;
            hold_q      <= '0;
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            resp_sent_q <= 1'b0;
            case (tx_state_q)
                TX_IDLE: begin
                    if (send_resp) begin
                        hold_q     <= resp;
                        trmt_q     <= 1'b1;
                        tx_state_q <= TX_BUSY;
                    end
                end
                default: begin
                    if (tx_done) begin
                        resp_sent_q <= 1'b1;
                        tx_state_q  <= TX_IDLE;
                    end
                end
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_comm_slv.sv
// Self-checking bench for uart_comm_slv: a serial peer drives RX and decodes TX,
// and a byte-queue command model supplies every expected value.
module tb_uart_comm_slv;

    localparam int BAUD = 16;
    localparam int TMO  = 2000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        RX          = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp   = 1'b0;
    logic [7:0]  resp        = 8'h00;
    logic        TX;
    logic        cmd_rdy;
    logic        resp_sent;
    logic [23:0] cmd;

    int checks      = 0;
    int failures    = 0;
    int n_resp_sent = 0;

    logic [7:0]  mon_q[$];
    logic [7:0]  part_q[$];
    logic [23:0] exp_cmd = 24'h0;
    logic        exp_rdy = 1'b0;

    uart_comm_slv #(
        .TIMEOUT_CYC (22'(TMO)),
        .BAUD_DIV    (16'(BAUD))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .resp_sent   (resp_sent)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resp_sent === 1'b1) n_resp_sent++;
    end

    // Peer receiver: decodes every frame seen on TX.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (TX === 1'b0) begin
                repeat (BAUD / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge clk);
                    b[i] = TX;
                end
                repeat (BAUD) @(negedge clk);
                mon_q.push_back(b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Command model: bytes collect in order; any idle gap longer than the
    // timeout discards a partial command; the third byte publishes it.
    function automatic void model_gap(input int cycles);
        if (cycles > TMO) part_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        part_q.push_back(b);
        if (part_q.size() == 3) begin
            exp_cmd = {part_q[0], part_q[1], part_q[2]};
            exp_rdy = 1'b1;
            part_q.delete();
        end
    endfunction

    function automatic void model_reset();
        part_q.delete();
        exp_cmd = 24'h0;
        exp_rdy = 1'b0;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = frame[i];
            repeat (BAUD) @(negedge clk);
        end
    endtask

    task automatic send_cmd(input logic [23:0] c);
        logic [7:0] b;
        for (int k = 0; k < 3; k++) begin
            b = c[23 - 8*k -: 8];
            send_byte(b);
            model_byte(b);
            check("cmd_val", cmd, exp_cmd);
            check("cmd_rdy", cmd_rdy, exp_rdy);
        end
        $display("INFO cmd sent=0x%06h cmd=0x%06h cmd_rdy=%0b", c, cmd, cmd_rdy);
    endtask

    task automatic wait_rx_rdy(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 12 * BAUD && !ok; i++) begin
            @(negedge clk);
            if (dut.rx_rdy === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic pulse_resp(input logic [7:0] b);
        resp      = b;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
    endtask

    task automatic wait_resp(input int c0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 14 * BAUD && !ok; i++) begin
            @(negedge clk);
            if (n_resp_sent > c0) ok = 1'b1;
        end
    endtask

    task automatic resp_txn(input logic [7:0] b);
        int c0;
        bit ok;
        c0 = n_resp_sent;
        mon_q.delete();
        pulse_resp(b);
        wait_resp(c0, ok);
        check("resp_done", ok, 1);
        repeat (4) @(negedge clk);
        check("resp_cnt", n_resp_sent - c0, 1);
        check("resp_nbytes", mon_q.size(), 1);
        if (mon_q.size() > 0) check("resp_byte", mon_q[0], b);
        $display("INFO resp sent=0x%02h frames=%0d", b, mon_q.size());
    endtask

    initial begin
        bit ok;
        int c0;
        int gap;
        logic [7:0] rb;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd", cmd, 24'h0);
        check("rst_cmd_rdy", cmd_rdy, 0);
        check("rst_tx", TX, 1);
        check("rst_resp_sent", resp_sent, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic command, cmd stable on bytes 0/1, one-cycle completion latency
        send_byte(8'hA5); model_byte(8'hA5);
        check("a5_b0_cmd", cmd, exp_cmd);
        send_byte(8'h3C); model_byte(8'h3C);
        check("a5_b1_cmd", cmd, exp_cmd);
        fork
            send_byte(8'h0F);
            begin
                wait_rx_rdy(ok);
                check("a5_rdy_seen", ok, 1);
                check("a5_lat_pre", cmd_rdy, 0);
                @(negedge clk);
                check("a5_lat_post", cmd_rdy, 1);
                check("a5_cmd", cmd, 24'hA53C0F);
            end
        join
        model_byte(8'h0F);
        $display("INFO cmd sent=0xa53c0f cmd=0x%06h cmd_rdy=%0b", cmd, cmd_rdy);

        // Partial command abandoned by timeout
        send_byte(8'h12); model_byte(8'h12);
        check("tmo_b0_cmd", cmd, exp_cmd);
        repeat (TMO + 10) @(negedge clk);
        model_gap(TMO + 10);
        send_cmd(24'h010203);
        check("tmo_cmd", cmd, 24'h010203);

        // Completion beats a simultaneous clear
        send_cmd(24'h111111);
        send_byte(8'h22); model_byte(8'h22);
        send_byte(8'h22); model_byte(8'h22);
        fork
            send_byte(8'h22);
            begin
                wait_rx_rdy(ok);
                check("race_rdy_seen", ok, 1);
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                check("race_cmd_rdy", cmd_rdy, 1);
                check("race_cmd", cmd, 24'h222222);
            end
        join
        model_byte(8'h22);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        exp_rdy = 1'b0;
        check("clr_cmd_rdy", cmd_rdy, exp_rdy);
        $display("INFO clr cmd=0x%06h cmd_rdy=%0b", cmd, cmd_rdy);

        // Held response byte, second request ignored while busy
        c0 = n_resp_sent;
        mon_q.delete();
        pulse_resp(8'hA5);
        resp = 8'hFF;
        repeat (5 * BAUD) @(negedge clk);
        pulse_resp(8'hFF);
        wait_resp(c0, ok);
        check("hold_done", ok, 1);
        repeat (14 * BAUD) @(negedge clk);
        check("hold_cnt", n_resp_sent - c0, 1);
        check("hold_nbytes", mon_q.size(), 1);
        if (mon_q.size() > 0) check("hold_byte", mon_q[0], 8'hA5);
        $display("INFO resp sent=0xa5 frames=%0d", mon_q.size());

        // Full duplex
        c0 = n_resp_sent;
        mon_q.delete();
        fork
            send_cmd(24'hDEAD01);
            begin
                pulse_resp(8'h5A);
                wait_resp(c0, ok);
                check("fd_resp_done", ok, 1);
            end
        join
        check("fd_cmd", cmd, 24'hDEAD01);
        check("fd_nbytes", mon_q.size(), 1);
        if (mon_q.size() > 0) check("fd_byte", mon_q[0], 8'h5A);

        // Reset mid-command and mid-response
        send_byte(8'h77); model_byte(8'h77);
        send_byte(8'h88); model_byte(8'h88);
        pulse_resp(8'h33);
        repeat (40) @(negedge clk);
        c0 = n_resp_sent;
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_tx", TX, 1);
        check("mrst_cmd", cmd, 24'h0);
        check("mrst_cmd_rdy", cmd_rdy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (14 * BAUD) @(negedge clk);
        check("mrst_no_resp_sent", n_resp_sent - c0, 0);
        mon_q.delete();
        send_cmd(24'h0A0B0C);
        check("mrst_cmd_after", cmd, 24'h0A0B0C);
        check("mrst_tx_quiet", mon_q.size(), 0);

        // Randomised byte stream with random gaps and acknowledges
        for (int i = 0; i < 30; i++) begin
            rb = 8'($urandom);
            send_byte(rb);
            model_byte(rb);
            check("rnd_cmd", cmd, exp_cmd);
            check("rnd_cmd_rdy", cmd_rdy, exp_rdy);
            $display("INFO rnd byte=0x%02h cmd=0x%06h cmd_rdy=%0b", rb, cmd, cmd_rdy);
            if ($urandom_range(0, 3) == 0) begin
                clr_cmd_rdy = 1'b1;
                @(negedge clk);
                clr_cmd_rdy = 1'b0;
                exp_rdy = 1'b0;
                check("rnd_clr", cmd_rdy, exp_rdy);
            end
            gap = ($urandom_range(0, 7) == 0) ? TMO + 50 : int'($urandom_range(0, 30));
            repeat (gap) @(negedge clk);
            model_gap(gap);
        end

        for (int i = 0; i < 4; i++) begin
            resp_txn(8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
